seq1010_scan_ctrl: RTL and testbench

Word-level controller that feeds a serial Moore "1010" detector. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first through the detector, one bit per clock. It counts the detector hits for that word and returns the count over a second valid/ready handshake. It sits between a parallel producer and the serial detection datapath, and it owns that datapath's sequencing, clear and mode configuration.

---
 rtl/seq1010_pkg.sv | 19 +
 rtl/seq1010_scan_ctrl_if.sv | 26 ++
 rtl/seq1010_det.sv | 45 ++++
 rtl/seq1010_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seq1010_scan_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seq1010_pkg.sv
// Shared encodings for the word-level "1010" scan controller and its serial detector.
package seq1010_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_e;

endpackage

// File: rtl/seq1010_scan_ctrl_if.sv
// Producer/consumer handshake bundle for seq1010_scan_ctrl.
interface seq1010_scan_ctrl_if #(
    parameter int W = 8
);
    localparam int CNT_W = $clog2(W / 2 + 1);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             overlap;
    logic             carry;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             busy;

    modport master (
        output in_valid, in_data, overlap, carry, out_ready,
        input  in_ready, out_valid, out_count, busy
    );

    modport slave (
        input  in_valid, in_data, overlap, carry, out_ready,
        output in_ready, out_valid, out_count, busy
    );
endinterface

// File: rtl/seq1010_det.sv
// Serial Moore "1010" detector with selectable overlap and a registered hit pulse.
module seq1010_det
    import seq1010_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    input  logic overlap,
    output logic hit
);
    det_state_e state_q, state_d;
    logic       hit_q, hit_d;

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            case (state_q)
                S0:      state_d = x ? S1 : S0;
                S1:      state_d = x ? S1 : S2;
                S2:      state_d = x ? S3 : S0;
                S3:      state_d = x ? S1 : S4;
                S4:      state_d = x ? (overlap ? S3 : S1) : S0;
                default: state_d = S0;
            endcase
        end
        // Only an enabled step into S4 fires; idling in S4 stays silent.
        hit_d = en && !clr && (state_d == S4);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
        end
    end

    assign hit = hit_q;
endmodule

// File: rtl/seq1010_scan_ctrl.sv
// Accepts a word, shifts it MSB-first through seq1010_det and returns the hit count.
module seq1010_scan_ctrl
    import seq1010_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    seq1010_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(W / 2 + 1);
    localparam int IDX_W = $clog2(W);

    ctrl_state_e      state_q, state_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             overlap_q, overlap_d;
    logic             carry_q, carry_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             det_clr, det_en, det_hit;

    // Clear is combinational on the accept edge so the first bit already sees S0.
    assign det_clr = (state_q == ST_IDLE) && bus.in_valid && !carry_d;
    assign det_en  = (state_q == ST_SHIFT);

    seq1010_det u_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (det_clr),
        .en      (det_en),
        .x       (shift_q[W-1]),
        .overlap (overlap_q),
        .hit     (det_hit)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        out_count_d = out_count_q;
        overlap_d   = overlap_q;
        carry_d     = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d   = bus.in_data;
                    overlap_d = bus.overlap;
                    carry_d   = bus.carry;
                    idx_d     = IDX_W'(W - 1);
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = {shift_q[W-2:0], 1'b0};
                idx_d   = idx_q - 1'b1;
                if (det_hit) cnt_d = cnt_q + 1'b1;
                if (idx_q == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last bit's hit lands here; latch the count including it.
                if (det_hit) cnt_d = cnt_q + 1'b1;
                out_count_d = cnt_d;
                state_d     = ST_REPORT;
            end
            ST_REPORT: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_REPORT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            out_count_q <= '0;
            overlap_q   <= 1'b0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            out_count_q <= out_count_d;
            overlap_q   <= overlap_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready is forced low during reset; the flop itself resets to the IDLE value.
    assign bus.in_ready  = in_ready_q && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_count = out_count_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_seq1010_scan_ctrl.sv
// Scoreboard bench for seq1010_scan_ctrl: expected counts queued at accept, popped at the output handshake.
module tb_seq1010_scan_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq1010_scan_ctrl_if #(.W(W)) bus ();

    seq1010_scan_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int m_state = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Independent reference detector over the bits of one word.
    task automatic model_word(input logic [W-1:0] d, input bit ov, input bit cy, output int cnt);
        int nxt;
        cnt = 0;
        if (!cy) m_state = 0;
        for (int i = W - 1; i >= 0; i--) begin
            case (m_state)
                0: nxt = d[i] ? 1 : 0;
                1: nxt = d[i] ? 1 : 2;
                2: nxt = d[i] ? 3 : 0;
                3: nxt = d[i] ? 1 : 4;
                default: nxt = d[i] ? (ov ? 3 : 1) : 0;
            endcase
            if (nxt == 4) cnt++;
            m_state = nxt;
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check_val("in_ready_idle", bus.in_ready, 1);
    endtask

    // exp_hard < 0 means use the reference model's count.
    task automatic run_word(input logic [W-1:0] d, input bit ov, input bit cy, input int exp_hard,
                            input int hold, input bit collide, input bit toggle);
        int mcnt, lat, exp_cnt, first_cnt;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.overlap  = ov;
        bus.carry    = cy;
        model_word(d, ov, cy, mcnt);
        exp_q.push_back(exp_hard >= 0 ? exp_hard : mcnt);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            if (toggle) begin
                bus.in_valid = 1'b1;
                bus.in_data  = W'($urandom);
                bus.overlap  = 1'($urandom_range(0, 1));
                bus.carry    = 1'($urandom_range(0, 1));
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        check_val("latency", lat + 1, W + 2);
        first_cnt = int'(bus.out_count);
        for (int i = 0; i < hold; i++) begin
            check_val("hold_out_valid", bus.out_valid, 1);
            check_val("hold_in_ready", bus.in_ready, 0);
            check_val("hold_count_stable", bus.out_count, first_cnt);
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        if (collide) bus.in_valid = 1'b1;
        exp_cnt = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check_val("count", bus.out_count, exp_cnt);
        $display("word %h ov=%0d cy=%0d count=%0d expected=%0d latency=%0d", d, ov, cy, bus.out_count, exp_cnt, lat + 1);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_val("in_ready_after", bus.in_ready, 1);
        check_val("busy_after", bus.busy, 0);
        check_val("out_valid_after", bus.out_valid, 0);
    endtask

    task automatic run_abort(input logic [W-1:0] d);
        int seen;
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.overlap  = 1'b1;
        bus.carry    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_val("abort_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("abort_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_state = 0;
        #1;
        check_val("abort_in_ready", bus.in_ready, 1);
        check_val("abort_out_valid", bus.out_valid, 0);
        check_val("abort_out_count", bus.out_count, 0);
        check_val("abort_busy", bus.busy, 0);
        seen = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        bus.out_ready = 1'b0;
        check_val("abort_no_output", seen, 0);
        $display("abort word %h: out_valid cycles after reset=%0d", d, seen);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.overlap   = 1'b0;
        bus.carry     = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_out_count", bus.out_count, 0);
        rst_n = 1'b1;
        #1;
        check_val("rst_release_in_ready", bus.in_ready, 1);

        run_word(8'b1010_1010, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0);
        run_word(8'b1010_1010, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);
        run_word(8'b0000_0101, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
        run_word(8'b0101_0101, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0);
        run_word(8'b0101_0101, 1'b1, 1'b0, 2, 0, 1'b0, 1'b0);
        run_word(8'b1010_1010, 1'b1, 1'b0, 3, 5, 1'b1, 1'b0);
        run_abort(8'b1010_1010);
        run_word(8'b1010_1010, 1'b0, 1'b0, 2, 0, 1'b0, 1'b1);
        run_word(8'b0101_0101, 1'b1, 1'b0, 2, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_word(W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1,
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_val("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
